cache_miss_controller: RTL and testbench

Sequencing controller placed between the CPU port and the set-associative tag/data array. It accepts one CPU request at a time and runs a single-cycle lookup in the array. On a miss it writes back a dirty victim to memory, refills from memory on a read miss, and then updates the array and returns one response pulse. It owns the memory-side request/response handshake so the array itself remains a pure storage and hit-detect block.

---
 rtl/cache_ctrl_pkg.sv | 26 ++
 rtl/cache_ctrl_perf.sv | 34 +++
 rtl/cache_miss_controller.sv | 186 ++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the cache miss controller.
// Optional performance counters are enabled with CACHE_CTRL_PERF_EN.
package cache_ctrl_pkg;

  localparam int ADDR_WIDTH_D = 16;
  localparam int DATA_WIDTH_D = 32;
  localparam int NUM_SETS_D   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_RF_REQ,
    S_RF_WAIT,
    S_UPDATE,
    S_RESP
  } state_t;

  // Sized by the package defaults; the top's width parameters must match them.
  typedef struct packed {
    logic                    rw;
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [DATA_WIDTH_D-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/cache_ctrl_perf.sv
// Three saturating event counters (hits, misses, write-backs).
// Built only when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit,
  input  logic        i_miss,
  input  logic        i_wb,
  output logic [31:0] o_hits,
  output logic [31:0] o_misses,
  output logic [31:0] o_wbs
);

  logic [31:0] r_hits;
  logic [31:0] r_misses;
  logic [31:0] r_wbs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_wbs    <= '0;
    end else begin
      if (i_hit && (r_hits != '1))     r_hits   <= r_hits + 32'd1;
      if (i_miss && (r_misses != '1))  r_misses <= r_misses + 32'd1;
      if (i_wb && (r_wbs != '1))       r_wbs    <= r_wbs + 32'd1;
    end
  end

  assign o_hits   = r_hits;
  assign o_misses = r_misses;
  assign o_wbs    = r_wbs;

endmodule

// File: rtl/cache_miss_controller.sv
// Sequences CPU lookups, dirty write-back, refill and array update for a cache.
// Define CACHE_CTRL_PERF_EN to build the hit/miss/write-back counters.
module cache_miss_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int NUM_SETS   = NUM_SETS_D,
  parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hit,
  output logic                  arr_lookup,
  output logic [ADDR_WIDTH-1:0] arr_addr,
  input  logic                  arr_hit,
  input  logic                  arr_victim_dirty,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  input  logic [TAG_WIDTH-1:0]  arr_victim_tag,
  input  logic [DATA_WIDTH-1:0] arr_victim_data,
  output logic                  arr_write,
  output logic                  arr_fill,
  output logic [DATA_WIDTH-1:0] arr_fill_data,
  output logic                  arr_fill_dirty,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses,
  output logic [31:0]           perf_wbs
);

  localparam int INDEX_WIDTH = $clog2(NUM_SETS);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_mem_valid;
  mem_req_t              r_mem_req;
  logic                  w_mem_valid_next;
  mem_req_t              w_mem_req_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    cpu_ready      = 1'b0;
    arr_lookup     = 1'b0;
    arr_write      = 1'b0;
    arr_fill       = 1'b0;
    arr_fill_data  = '0;
    arr_fill_dirty = 1'b0;
    cpu_rsp_valid  = 1'b0;
    cpu_hit        = 1'b0;
    cpu_rdata      = '0;
    case (r_state)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) w_state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        arr_lookup = 1'b1;
        // A write hit shares the fill data path to carry the registered write data.
        arr_write  = arr_hit & r_rw;
        if (arr_hit && r_rw) begin
          arr_fill_data  = r_wdata;
          arr_fill_dirty = 1'b1;
        end
        if (arr_hit)               w_state_next = S_RESP;
        else if (arr_victim_dirty) w_state_next = S_WB_REQ;
        else                       w_state_next = r_rw ? S_UPDATE : S_RF_REQ;
      end
      S_WB_REQ:  if (mem_req_ready) w_state_next = r_rw ? S_UPDATE : S_RF_REQ;
      S_RF_REQ:  if (mem_req_ready) w_state_next = S_RF_WAIT;
      S_RF_WAIT: if (mem_rsp_valid) w_state_next = S_UPDATE;
      S_UPDATE: begin
        arr_fill       = 1'b1;
        arr_fill_data  = r_rw ? r_wdata : r_rdata;
        arr_fill_dirty = r_rw;
        w_state_next   = S_RESP;
      end
      S_RESP: begin
        cpu_rsp_valid = 1'b1;
        cpu_hit       = r_hit;
        cpu_rdata     = r_rw ? '0 : r_rdata;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The memory request is loaded only on entry to a request state, so it stays
  // frozen while the memory side stalls.
  always_comb begin
    w_mem_valid_next = (w_state_next == S_WB_REQ) || (w_state_next == S_RF_REQ);
    w_mem_req_next   = r_mem_req;
    if (!w_mem_valid_next) begin
      w_mem_req_next = '0;
    end else if (w_state_next != r_state) begin
      if (w_state_next == S_WB_REQ)
        w_mem_req_next = '{rw: 1'b1, addr: {arr_victim_tag, r_addr[INDEX_WIDTH-1:0]},
                           wdata: arr_victim_data};
      else
        w_mem_req_next = '{rw: 1'b0, addr: r_addr, wdata: '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_req   <= '0;
    end else begin
      r_mem_valid <= w_mem_valid_next;
      r_mem_req   <= w_mem_req_next;
      if (r_state == S_IDLE && cpu_valid) begin
        r_addr  <= cpu_addr;
        r_rw    <= cpu_rw;
        r_wdata <= cpu_wdata;
      end
      if (r_state == S_LOOKUP) begin
        r_hit   <= arr_hit;
        r_rdata <= arr_hit ? arr_rdata : '0;
      end
      if (r_state == S_RF_WAIT && mem_rsp_valid) r_rdata <= mem_rsp_rdata;
    end
  end

  assign arr_addr      = r_addr;
  assign mem_req_valid = r_mem_valid;
  assign mem_req_rw    = r_mem_req.rw;
  assign mem_req_addr  = r_mem_req.addr;
  assign mem_req_wdata = r_mem_req.wdata;

`ifdef CACHE_CTRL_PERF_EN
  logic w_cnt_hit;
  logic w_cnt_miss;
  logic w_cnt_wb;

  assign w_cnt_hit  = (r_state == S_LOOKUP) &&  arr_hit;
  assign w_cnt_miss = (r_state == S_LOOKUP) && !arr_hit;
  assign w_cnt_wb   = (r_state == S_WB_REQ) &&  mem_req_ready;

  cache_ctrl_perf u_perf (
    .clk      (clk),
    .rst      (rst),
    .i_hit    (w_cnt_hit),
    .i_miss   (w_cnt_miss),
    .i_wb     (w_cnt_wb),
    .o_hits   (perf_hits),
    .o_misses (perf_misses),
    .o_wbs    (perf_wbs)
  );
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
  assign perf_wbs    = '0;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: table of hit vectors plus
// hand-written miss, write-back and reset sequences (honours CACHE_CTRL_PERF_EN).
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        arr_lookup;
  logic [15:0] arr_addr;
  logic        arr_hit = 1'b0;
  logic        arr_victim_dirty = 1'b0;
  logic [31:0] arr_rdata = '0;
  logic [9:0]  arr_victim_tag = '0;
  logic [31:0] arr_victim_data = '0;
  logic        arr_write;
  logic        arr_fill;
  logic [31:0] arr_fill_data;
  logic        arr_fill_dirty;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_rw;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
  logic [31:0] perf_wbs;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] arr_rdata;
    logic [31:0] exp_rdata;
  } hit_vec_t;

  hit_vec_t vecs [4];

  always #5 clk = ~clk;

  cache_miss_controller dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .arr_lookup(arr_lookup), .arr_addr(arr_addr),
    .arr_hit(arr_hit), .arr_victim_dirty(arr_victim_dirty), .arr_rdata(arr_rdata),
    .arr_victim_tag(arr_victim_tag), .arr_victim_data(arr_victim_data),
    .arr_write(arr_write), .arr_fill(arr_fill),
    .arr_fill_data(arr_fill_data), .arr_fill_dirty(arr_fill_dirty),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"},      32'(cpu_ready), 32'd1);
    check({tag, "_cpu_rsp_valid"},  32'(cpu_rsp_valid), 32'd0);
    check({tag, "_cpu_rdata"},      cpu_rdata, 32'd0);
    check({tag, "_cpu_hit"},        32'(cpu_hit), 32'd0);
    check({tag, "_arr_lookup"},     32'(arr_lookup), 32'd0);
    check({tag, "_arr_addr"},       32'(arr_addr), 32'd0);
    check({tag, "_arr_write"},      32'(arr_write), 32'd0);
    check({tag, "_arr_fill"},       32'(arr_fill), 32'd0);
    check({tag, "_arr_fill_data"},  arr_fill_data, 32'd0);
    check({tag, "_arr_fill_dirty"}, 32'(arr_fill_dirty), 32'd0);
    check({tag, "_mem_req_valid"},  32'(mem_req_valid), 32'd0);
    check({tag, "_mem_req_rw"},     32'(mem_req_rw), 32'd0);
    check({tag, "_mem_req_addr"},   32'(mem_req_addr), 32'd0);
    check({tag, "_mem_req_wdata"},  mem_req_wdata, 32'd0);
    check({tag, "_perf_hits"},      perf_hits, 32'd0);
    check({tag, "_perf_misses"},    perf_misses, 32'd0);
    check({tag, "_perf_wbs"},       perf_wbs, 32'd0);
  endtask

  // Accept at edge N, LOOKUP in N+1, response in N+2, ready again in N+3.
  task automatic run_hit(input hit_vec_t v);
    cpu_valid = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr; cpu_wdata = v.wdata;
    arr_hit = 1'b1; arr_victim_dirty = 1'b0; arr_rdata = v.arr_rdata;
    #1 check("hit_accept_ready", 32'(cpu_ready), 32'd1);
    tick();
    cpu_valid = 1'b0; cpu_wdata = ~v.wdata; cpu_addr = ~v.addr;
    #1;
    check("hit_lookup", 32'(arr_lookup), 32'd1);
    check("hit_arr_addr", 32'(arr_addr), 32'(v.addr));
    check("hit_arr_write", 32'(arr_write), 32'(v.rw));
    check("hit_busy_ready", 32'(cpu_ready), 32'd0);
    check("hit_no_mem_lookup", 32'(mem_req_valid), 32'd0);
    tick();
    arr_hit = 1'b0; arr_rdata = 32'h0BAD_F00D;
    #1;
    check("hit_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
    check("hit_rsp_hit", 32'(cpu_hit), 32'd1);
    check("hit_rsp_rdata", cpu_rdata, v.exp_rdata);
    check("hit_no_mem_resp", 32'(mem_req_valid), 32'd0);
    tick();
    check("hit_idle_ready", 32'(cpu_ready), 32'd1);
    check("hit_rsp_pulse_end", 32'(cpu_rsp_valid), 32'd0);
  endtask

  // Read miss at 16'h1C05 (index 5) with dirty victim tag 3 -> write-back to 16'h00C5.
  task automatic run_dirty_read_miss();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1C05; cpu_wdata = '0;
    arr_hit = 1'b0; arr_victim_dirty = 1'b1; arr_victim_tag = 10'h003;
    arr_victim_data = 32'hDEAD_0003; arr_rdata = 32'h7777_7777;
    tick();
    cpu_valid = 1'b0;
    #1 check("dm_lookup", 32'(arr_lookup), 32'd1);
    check("dm_no_write", 32'(arr_write), 32'd0);
    tick();
    arr_victim_tag = 10'h2AA; arr_victim_data = 32'h0; arr_victim_dirty = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("dm_wb_valid", 32'(mem_req_valid), 32'd1);
      check("dm_wb_rw", 32'(mem_req_rw), 32'd1);
      check("dm_wb_addr", 32'(mem_req_addr), 32'h0000_00C5);
      check("dm_wb_wdata", mem_req_wdata, 32'hDEAD_0003);
      tick();
    end
    mem_req_ready = 1'b1;
    #1 check("dm_wb_hold_addr", 32'(mem_req_addr), 32'h0000_00C5);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("dm_rf_valid", 32'(mem_req_valid), 32'd1);
    check("dm_rf_rw", 32'(mem_req_rw), 32'd0);
    check("dm_rf_addr", 32'(mem_req_addr), 32'h0000_1C05);
    // Same-cycle accept and response must drop the response.
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    check("dm_wait_valid_low", 32'(mem_req_valid), 32'd0);
    check("dm_wait_no_fill", 32'(arr_fill), 32'd0);
    tick();
    check("dm_wait2_no_fill", 32'(arr_fill), 32'd0);
    check("dm_wait2_no_rsp", 32'(cpu_rsp_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    #1;
    check("dm_fill", 32'(arr_fill), 32'd1);
    check("dm_fill_data", arr_fill_data, 32'h1234_5678);
    check("dm_fill_dirty", 32'(arr_fill_dirty), 32'd0);
    check("dm_fill_addr", 32'(arr_addr), 32'h0000_1C05);
    tick();
    check("dm_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
    check("dm_rsp_hit", 32'(cpu_hit), 32'd0);
    check("dm_rsp_rdata", cpu_rdata, 32'h1234_5678);
    tick();
    check("dm_idle_ready", 32'(cpu_ready), 32'd1);
  endtask

  // Clean write miss: no memory traffic, fill with write data, response 3 cycles after accept.
  task automatic run_clean_write_miss();
    cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 32'hCAFE_F00D;
    arr_hit = 1'b0; arr_victim_dirty = 1'b0;
    tick();
    cpu_valid = 1'b0; cpu_wdata = '0;
    #1;
    check("cw_lookup", 32'(arr_lookup), 32'd1);
    check("cw_no_write", 32'(arr_write), 32'd0);
    check("cw_no_mem1", 32'(mem_req_valid), 32'd0);
    tick();
    check("cw_fill", 32'(arr_fill), 32'd1);
    check("cw_fill_data", arr_fill_data, 32'hCAFE_F00D);
    check("cw_fill_dirty", 32'(arr_fill_dirty), 32'd1);
    check("cw_no_mem2", 32'(mem_req_valid), 32'd0);
    check("cw_no_rsp_yet", 32'(cpu_rsp_valid), 32'd0);
    tick();
    check("cw_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
    check("cw_rsp_hit", 32'(cpu_hit), 32'd0);
    check("cw_rsp_rdata", cpu_rdata, 32'd0);
    tick();
    check("cw_idle_ready", 32'(cpu_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 16'h0040, wdata: 32'h0,         arr_rdata: 32'hA5A5_0001, exp_rdata: 32'hA5A5_0001};
    vecs[1] = '{rw: 1'b1, addr: 16'h0123, wdata: 32'h0000_BEEF, arr_rdata: 32'h5555_AAAA, exp_rdata: 32'h0};
    vecs[2] = '{rw: 1'b0, addr: 16'hFFFF, wdata: 32'h0,         arr_rdata: 32'hFFFF_FFFF, exp_rdata: 32'hFFFF_FFFF};
    vecs[3] = '{rw: 1'b0, addr: 16'h0000, wdata: 32'h0,         arr_rdata: 32'h8000_0001, exp_rdata: 32'h8000_0001};

    #12 check_reset_outputs("por");
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_hit(vecs[i]);
    run_dirty_read_miss();
    run_clean_write_miss();

    // Reset during RF_WAIT, then a late memory response that must be ignored.
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0301; arr_hit = 1'b0; arr_victim_dirty = 1'b0;
    tick();
    cpu_valid = 1'b0;
    tick();
    check("rst_rf_valid", 32'(mem_req_valid), 32'd1);
    check("rst_rf_addr", 32'(mem_req_addr), 32'h0000_0301);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("late_rsp_no_rsp", 32'(cpu_rsp_valid), 32'd0);
      check("late_rsp_no_fill", 32'(arr_fill), 32'd0);
      check("late_rsp_ready", 32'(cpu_ready), 32'd1);
    end
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    run_hit(vecs[0]);

    // Counter scenario from a clean reset: 2 hits, 1 dirty miss, 1 clean miss.
    @(negedge clk) rst = 1'b1;
    #1 check_reset_outputs("perfrst");
    @(negedge clk) rst = 1'b0;
    tick();
    run_hit(vecs[0]);
    run_hit(vecs[1]);
    run_dirty_read_miss();
    run_clean_write_miss();
`ifdef CACHE_CTRL_PERF_EN
    check("perf_hits", perf_hits, 32'd2);
    check("perf_misses", perf_misses, 32'd2);
    check("perf_wbs", perf_wbs, 32'd1);
`else
    check("perf_hits", perf_hits, 32'd0);
    check("perf_misses", perf_misses, 32'd0);
    check("perf_wbs", perf_wbs, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
